// File: rtl/hazard_pkg.sv
// Shared defaults, producer latency constants and width helper for the
// hazard scoreboard.
package hazard_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int REG_AW_DEF   = 5;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL  = 3;

  // Bits needed to hold values 0..value-1. Never less than 1, so that a
  // degenerate range still yields a legal vector width.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// Countdown register for one scoreboard slot: loads on set, otherwise
// counts down to zero and holds there.
module hazard_sb_entry
#(
  parameter int LW = 3
)
(
  input  logic          clk,
  input  logic          reset,
  input  logic          set,
  input  logic [LW-1:0] set_val,
  output logic [LW-1:0] cnt,
  output logic          busy
);

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (set)
      cnt <= set_val;
    else if (cnt != '0)
      cnt <= cnt - LW'(1);
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: per-register countdown scoreboard for in-flight
// writes, stretched branch flush and a saturating stall counter.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_REGS     = NUM_REGS_DEF,
  parameter int REG_AW       = REG_AW_DEF,
  parameter int MAX_LAT      = 7,
  parameter int FLUSH_CYCLES = 1,
  parameter int PERF_W       = 32,
  localparam int LW          = clog2(MAX_LAT + 1)
)
(
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]   id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic                id_we,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic [LW-1:0]       id_lat,
  input  logic                branch_taken,
  output logic                stall,
  output logic                branch_flush,
  output logic                issue_fire,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [PERF_W-1:0]   stall_count
);

  localparam int FW    = clog2(FLUSH_CYCLES + 1);
  localparam int SLOTS = 1 << REG_AW;

  logic [LW-1:0]    cnt [SLOTS];
  logic [SLOTS-1:0] busy;
  logic [FW-1:0]    flush_cnt;
  logic             flush_active;
  logic             flush_start;
  logic             hit_rs;
  logic             hit_rt;
  logic             wr_en;
  logic [LW-1:0]    lat_c;
  logic [LW-1:0]    dec_val;
  logic [LW-1:0]    set_val;

  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  // Slots beyond NUM_REGS (index space wider than the register file) read as idle.
  for (genvar r = 1; r < SLOTS; r++) begin : g_slot
    if (r < NUM_REGS) begin : g_entry
      hazard_sb_entry #(.LW(LW)) u_entry (
        .clk     (clk),
        .reset   (reset),
        .set     (wr_en && (id_rd == REG_AW'(r))),
        .set_val (set_val),
        .cnt     (cnt[r]),
        .busy    (busy[r])
      );
    end else begin : g_idle
      assign cnt[r]  = '0;
      assign busy[r] = 1'b0;
    end
  end

  assign pending_mask = busy[NUM_REGS-1:0];

  assign flush_active = (flush_cnt != '0);
  assign hit_rs       = id_use_rs & busy[id_rs];
  assign hit_rt       = id_use_rt & busy[id_rt];
  assign stall        = id_valid & (hit_rs | hit_rt) & ~flush_active;
  assign flush_start  = branch_taken & ~stall & ~flush_active;
  assign branch_flush = flush_start | flush_active;
  assign issue_fire   = id_valid & ~stall & ~branch_flush;
  assign wr_en        = issue_fire & id_we & (id_rd != '0);

  // An older, slower write to the same register is never shortened.
  always_comb begin
    lat_c = id_lat;
    if ({1'b0, id_lat} > (LW + 1)'(MAX_LAT))
      lat_c = LW'(MAX_LAT);
    dec_val = (cnt[id_rd] != '0) ? cnt[id_rd] - LW'(1) : '0;
    set_val = (lat_c > dec_val) ? lat_c : dec_val;
  end

  always_ff @(posedge clk) begin
    if (reset)
      flush_cnt <= '0;
    else if (flush_start)
      flush_cnt <= FW'(FLUSH_CYCLES - 1);
    else if (flush_active)
      flush_cnt <= flush_cnt - FW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (stall && (stall_count != '1))
      stall_count <= stall_count + PERF_W'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed scenarios followed by random
// traffic, all compared cycle by cycle with a busy-until-cycle reference model.
module tb_hazard_scoreboard_unit;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int ML = 5;
  localparam int FC = 2;
  localparam int PW = 4;
  localparam int LW = 3;

  logic          clk;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_we;
  logic [AW-1:0] id_rd;
  logic [LW-1:0] id_lat;
  logic          branch_taken;
  logic          stall;
  logic          branch_flush;
  logic          issue_fire;
  logic [NR-1:0] pending_mask;
  logic [PW-1:0] stall_count;

  hazard_scoreboard_unit #(
    .NUM_REGS(NR), .REG_AW(AW), .MAX_LAT(ML), .FLUSH_CYCLES(FC), .PERF_W(PW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_we        (id_we),
    .id_rd        (id_rd),
    .id_lat       (id_lat),
    .branch_taken (branch_taken),
    .stall        (stall),
    .branch_flush (branch_flush),
    .issue_fire   (issue_fire),
    .pending_mask (pending_mask),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the last cycle number at which each register is still
  // pending, the last cycle of the flush window, and the stall tally.
  int k;
  int last_busy [NR];
  int flush_last;
  int sc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
  endtask

  function automatic bit pend(input int r);
    return (r != 0) && (last_busy[r] >= k);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) last_busy[i] = -1;
    flush_last = -1;
    sc = 0;
  endtask

  task automatic step(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                      input logic urs, input logic urt, input logic we,
                      input logic [AW-1:0] rd, input logic [LW-1:0] lat,
                      input logic bt, input logic rst);
    bit f_act, e_stall, f_start, e_flush, e_fire;
    logic [NR-1:0] e_mask;
    int eff_lat;
    @(negedge clk);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_we = we; id_rd = rd; id_lat = lat; branch_taken = bt; reset = rst;
    #1;
    f_act   = (flush_last >= k);
    e_stall = v && ((urs && pend(int'(rs))) || (urt && pend(int'(rt)))) && !f_act;
    f_start = bt && !e_stall && !f_act;
    e_flush = f_start || f_act;
    e_fire  = v && !e_stall && !e_flush;
    for (int i = 0; i < NR; i++) e_mask[i] = pend(i);
    check("stall", 32'(stall), 32'(e_stall));
    check("branch_flush", 32'(branch_flush), 32'(e_flush));
    check("issue_fire", 32'(issue_fire), 32'(e_fire));
    check("pending_mask", 32'(pending_mask), 32'(e_mask));
    check("stall_count", 32'(stall_count), 32'(sc));
    if (rst) begin
      model_reset();
    end else begin
      if (f_start) flush_last = k + FC - 1;
      if (e_stall && sc < (1 << PW) - 1) sc++;
      if (e_fire && we && rd != 0) begin
        eff_lat = (int'(lat) > ML) ? ML : int'(lat);
        if (k + eff_lat > last_busy[rd]) last_busy[rd] = k + eff_lat;
      end
    end
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    k = 0;
    model_reset();
    reset = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_we = 0; id_rd = 0; id_lat = 0; branch_taken = 0;
    repeat (2) @(posedge clk);
    idle(1);
    check("reset_stall_count", 32'(stall_count), 32'd0);

    // load r8 then dependent add: one bubble
    step(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    step(1, 8, 1, 1, 1, 1, 9, 0, 0, 0);
    step(1, 8, 1, 1, 1, 1, 9, 0, 0, 0);
    check("lw_bubble_count", 32'(stall_count), 32'd1);
    idle(2);

    // mul r5 then reader via rt, with and without use_rt
    step(1, 0, 0, 0, 0, 1, 5, 3, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 2, 5, 1, 1, 1, 6, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 1, 5, 3, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 2, 5, 1, 0, 0, 0, 0, 0, 0);
    idle(4);

    // WAW: slow mul r4 followed by fast alu r4, then a reader
    step(1, 0, 0, 0, 0, 1, 4, 3, 0, 0);
    step(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 4, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);

    // branch flush window with a second branch inside it
    step(1, 0, 0, 0, 0, 1, 7, 2, 1, 0);
    step(1, 0, 0, 0, 0, 1, 7, 2, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // r0 is never tracked
    step(1, 0, 0, 0, 0, 1, 0, 3, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    idle(1);

    // reset in the second cycle of a lat-3 stall
    step(1, 0, 0, 0, 0, 1, 6, 3, 0, 0);
    step(1, 6, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 6, 0, 1, 0, 0, 0, 0, 0, 1);
    step(1, 6, 0, 1, 0, 0, 0, 0, 0, 0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_fire", 32'(issue_fire), 32'd1);
    check("rst_mid_count", 32'(stall_count), 32'd0);

    // clamp: lat 7 behaves as MAX_LAT
    step(1, 0, 0, 0, 0, 1, 3, 7, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom_range(0, 7)),
           LW'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
